// File: rtl/fifo_reader.sv
// fifo_reader: drains an external FIFO into a small output buffer and
// presents the words downstream through a valid/ready port.
// Ports: clk, rst (sync, active-high); en starts/stops draining;
// empty/almostempty/underflow/data_out come from the FIFO and
// rd_en goes back to it.
// m_data/m_valid/m_ready form the downstream port.
// busy is high outside IDLE; err_underflow is a sticky underflow flag;
// words_read counts delivered words.
// Optional macro FIFO_READER_STATS_EN builds the words_read counter;
// without it words_read is tied to 0.
module fifo_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  empty,
  input  logic                  almostempty,
  input  logic                  underflow,
  input  logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  err_underflow,
  output logic [15:0]           words_read
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = AW + 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nx;
  logic                  pend;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [FIFO_WIDTH-1:0] mem [BUF_DEPTH];

  logic          capture;
  logic          transfer;
  logic [SW-1:0] occ_sum;
  logic          room;
  logic          rd_nx;

  assign capture  = pend;
  assign m_valid  = (count != '0);
  assign transfer = m_valid && m_ready;
  assign m_data   = mem[rd_ptr];
  assign busy     = (state != IDLE);

  // Words already requested (rd_en) or arriving (pend) reserve a slot,
  // so the buffer cannot be overrun by reads already in flight.
  assign occ_sum = SW'(count) + SW'(rd_en) + SW'(pend) + SW'(1);
  assign room    = (occ_sum <= SW'(BUF_DEPTH));

  // Holding off while rd_en && almostempty keeps us from reading the
  // last FIFO word twice before the empty flag catches up.
  assign rd_nx = (state == RUN) && !empty &&
                 !(rd_en && almostempty) && room;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = RUN;
      RUN:     if (!en) state_nx = DRAIN;
      DRAIN: begin
        if (en)
          state_nx = RUN;
        else if (!rd_en && !pend && count == '0)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rd_en         <= 1'b0;
      pend          <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_underflow <= 1'b0;
    end else begin
      state <= state_nx;
      rd_en <= rd_nx;
      pend  <= rd_en;
      if (capture)
        wr_ptr <= wr_ptr + AW'(1);
      if (transfer)
        rd_ptr <= rd_ptr + AW'(1);
      if (capture && !transfer)
        count <= count + CW'(1);
      else if (!capture && transfer)
        count <= count - CW'(1);
      if (underflow)
        err_underflow <= 1'b1;
    end
  end

  // Storage carries no reset; a capture on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst && capture)
      mem[wr_ptr] <= data_out;
  end

`ifdef FIFO_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      words_read <= '0;
    else if (transfer && words_read != 16'hFFFF)
      words_read <= words_read + 16'd1;
  end
`else
  assign words_read = 16'd0;
`endif

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, SHALL set the data word width.
REQ-002 Parameter BUF_DEPTH, default 4, SHALL set the internal output-buffer depth in entries; legal values are 4, 8 and 16.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset: synchronous and active-high.
REQ-005 Port en, input, 1 bit, SHALL request draining of the FIFO.
REQ-006 Port empty, input, 1 bit, SHALL carry the FIFO empty flag.
REQ-007 Port almostempty, input, 1 bit, SHALL carry the FIFO almostempty flag (count == 1).
REQ-008 Port underflow, input, 1 bit, SHALL carry the FIFO underflow flag.
REQ-009 Port data_out, input, FIFO_WIDTH bits, SHALL carry FIFO read data, valid the cycle after an accepted rd_en.
REQ-010 Port rd_en, output, 1 bit, SHALL be the registered FIFO read request.
REQ-011 Port m_data, output, FIFO_WIDTH bits, SHALL be the downstream data, i.e. the buffer head.
REQ-012 Port m_valid, output, 1 bit, SHALL be high when the buffer is non-empty.
REQ-013 Port m_ready, input, 1 bit, SHALL be the downstream accept; a transfer occurs when m_valid && m_ready.
REQ-014 Port busy, output, 1 bit, SHALL be high in any state other than IDLE.
REQ-015 Port err_underflow, output, 1 bit, SHALL be a sticky flag set when underflow is seen high.
REQ-016 Port words_read, output, 16 bits, SHALL be the count of words delivered downstream.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DRAIN.
- IDLE->RUN when en=1.
- RUN->DRAIN when en=0.
- DRAIN->RUN when en=1.
- DRAIN->IDLE when rd_en=0, pend=0 and the buffer is empty.
REQ-018 pend SHALL be a 1-bit register equal to rd_en delayed by one cycle; it marks that data_out is to be captured this cycle.
REQ-019 When pend=1, data_out SHALL be written into the buffer tail on the same clock edge.
REQ-020 The next-cycle value of rd_en SHALL be 1 only when all of the following hold:
- state is RUN;
- empty=0;
- !(rd_en && almostempty), so the last FIFO word is not double-read;
- occupancy + rd_en + pend + 1 <= BUF_DEPTH.
REQ-021 When the occupancy condition of REQ-020 holds, rd_en SHALL sustain one read per cycle while m_ready=1.
REQ-022 Occupancy SHALL be:
- +1 on capture only;
- -1 on transfer only;
- unchanged on a simultaneous capture and transfer.
REQ-023 The buffer SHALL never overflow; a write to a full buffer is a design error.
REQ-024 Buffer pointers SHALL wrap modulo BUF_DEPTH.
REQ-025 m_data SHALL remain stable while m_valid=1 and m_ready=0.
REQ-026 Words SHALL be delivered in FIFO read order, with no loss or duplication.
REQ-027 err_underflow SHALL set the cycle after underflow=1 and hold until reset.
REQ-028 words_read SHALL increment on each transfer and saturate at 16'hFFFF.
REQ-029 A word already in flight (rd_en or pend high) when en falls SHALL still be captured and delivered in DRAIN.

Reset
REQ-030 With rst=1 at a rising edge, the following SHALL clear to 0 and state SHALL go to IDLE:
- rd_en, pend, m_valid, busy, err_underflow, words_read;
- buffer pointers and occupancy.
REQ-031 m_data after reset SHALL be don't-care, since m_valid=0.
REQ-032 Reset mid-operation SHALL discard buffered and in-flight words; a pend capture on the reset edge SHALL be dropped.

Configuration
REQ-033 Macro FIFO_READER_STATS_EN: when defined, words_read SHALL behave as in REQ-028.
REQ-034 When FIFO_READER_STATS_EN is undefined, words_read SHALL be tied to 0 and no counter logic SHALL be built.

Verification
REQ-035 Reset, then en=1, empty=1 -> rd_en=0, m_valid=0, state RUN, busy=1.
REQ-036 FIFO holds 8 words 0x0001..0x0008, m_ready=1 -> exactly 8 rd_en pulses, back-to-back; m_data 0x0001..0x0008 in order; words_read=8; err_underflow=0.
REQ-037 FIFO holds 1 word, almostempty=1 -> a single rd_en pulse, no second read, no underflow.
REQ-038 m_ready=0 with 8 words available -> rd_en stops once occupancy + in-flight reaches 4; m_data holds 0x0001. Then m_ready=1 -> remaining words delivered in order, none lost.
REQ-039 en dropped with rd_en=1 and pend=1 -> both words delivered, then IDLE with busy=0.
REQ-040 underflow pulsed -> err_underflow=1 the next cycle, held until rst=1. rst mid-stream -> m_valid=0 and words_read=0 the next cycle.
